opl3_reg_write_queue: RTL

- Host-side front end for the OPL3 register file. It decodes host bus cycles: an address-latch write followed by a data write.
- Each (address, data) pair is buffered in a small FIFO. Pairs are drained into the write port of the register-file RAM, one per cycle, only when the sample pipeline grants a write window.
- Sits directly upstream of the simple dual-port register RAM: drives its wea/addra/dia. The RAM's read port stays owned by the operator pipeline.

---
 rtl/opl3_reg_write_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/opl3_reg_write_queue.sv
// ---------------------------------------------------------------------------
// opl3_reg_write_queue
//
// This is the host-side front end for the OPL3 register file. The host first
// writes a register address and then the register data. Each completed
// (address, data) pair goes into a small FIFO. The FIFO drains into the write
// port of the register-file RAM, at most one entry per cycle, and only while
// the sample pipeline grants a write window.
//
// Ports:
//   clk             system clock; all state changes on the rising edge
//   reset           asynchronous, active-high reset
//   wr              host write strobe; each asserted cycle is one write
//   a[1:0]          a[0]: 0 = address latch, 1 = data; a[1]: register bank
//   din             host write data
//   write_window    a RAM write is allowed on the next cycle
//   clear_overflow  clears the sticky overflow flag
//   busy            FIFO full (registered)
//   overflow        sticky; a data write was dropped because the FIFO was full
//   ram_we          RAM write enable (wea)
//   ram_addr        RAM write address (addra), {bank, register index}
//   ram_din         RAM write data (dia)
// ---------------------------------------------------------------------------
module opl3_reg_write_queue #(
    parameter int FIFO_DEPTH     = 4,
    parameter int REG_ADDR_WIDTH = 9,
    parameter int REG_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [1:0]                a,
    input  logic [REG_DATA_WIDTH-1:0] din,
    input  logic                      write_window,
    input  logic                      clear_overflow,
    output logic                      busy,
    output logic                      overflow,
    output logic                      ram_we,
    output logic [REG_ADDR_WIDTH-1:0] ram_addr,
    output logic [REG_DATA_WIDTH-1:0] ram_din
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = REG_ADDR_WIDTH + REG_DATA_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Each FIFO entry is stored as {address, data}.
    logic [EW-1:0]             mem_q [FIFO_DEPTH];

    logic [REG_ADDR_WIDTH-1:0] addr_latch_q, addr_latch_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      busy_q, busy_d;
    logic                      overflow_q, overflow_d;
    logic                      ram_we_q, ram_we_d;
    logic [REG_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [REG_DATA_WIDTH-1:0] ram_din_q, ram_din_d;

    logic pop;
    logic push_req;
    logic push_ok;
    logic drop;

    // The pop check uses the count before the edge. A pair pushed into an
    // empty FIFO therefore always waits at least one cycle before it drains.
    assign pop      = (count_q != '0) && write_window;
    assign push_req = wr && a[0];
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign push_ok  = push_req && ((count_q < DEPTH_C) || pop);
    assign drop     = push_req && !push_ok;

    always_comb begin
        addr_latch_d = addr_latch_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;

        // The latch is never cleared, so repeated data writes reuse the last
        // address written.
        if (wr && !a[0]) begin
            addr_latch_d = {a[1], din[REG_ADDR_WIDTH-2:0]};
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            ram_we_d   = 1'b1;
            ram_addr_d = mem_q[rd_ptr_q][EW-1:REG_DATA_WIDTH];
            ram_din_d  = mem_q[rd_ptr_q][REG_DATA_WIDTH-1:0];
            rd_ptr_d   = rd_ptr_q + 1'b1;
        end

        count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};

        // If a clear and a new drop happen on the same edge, the drop wins.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end

        busy_d = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_latch_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
        end else begin
            addr_latch_q <= addr_latch_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
        end
    end

    // Storage needs no reset. Stale entries can never be read because the
    // count and the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {addr_latch_q, din};
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule
